// File: rtl/decode_issue_controller_pkg.sv
// Shared types and constants for the decode/issue controller and its scoreboard.
package decode_issue_controller_pkg;

  localparam int REG_COUNT      = 32;
  localparam int INFLIGHT_W     = 4;
  localparam int PEND_W_DEFAULT = 2;

  typedef logic [PEND_W_DEFAULT-1:0] pend_cnt_t;

  typedef enum logic {
    RUN,
    SERIAL_BUSY
  } IssueState;

endpackage

// File: rtl/decode_issue_controller_if.sv
// Decode-to-issue handshake plus the completion bus feeding the scoreboard.
interface decode_issue_controller_if;

  logic       dec_valid;
  logic [4:0] dec_src1;
  logic [4:0] dec_src2;
  logic       dec_uses_src1;
  logic       dec_uses_src2;
  logic [4:0] dec_dst;
  logic       dec_writes_dst;
  logic       dec_serial;
  logic       iss_ready;
  logic       iss_valid;
  logic       dec_stall;
  logic       cmpl_valid;
  logic       cmpl_writes_dst;
  logic [4:0] cmpl_dst;

  modport master (
    output dec_valid, dec_src1, dec_src2, dec_uses_src1, dec_uses_src2,
           dec_dst, dec_writes_dst, dec_serial, iss_ready,
           cmpl_valid, cmpl_writes_dst, cmpl_dst,
    input  iss_valid, dec_stall
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src2, dec_uses_src1, dec_uses_src2,
           dec_dst, dec_writes_dst, dec_serial, iss_ready,
           cmpl_valid, cmpl_writes_dst, cmpl_dst,
    output iss_valid, dec_stall
  );

endinterface

// File: rtl/decode_issue_controller_issue_scoreboard.sv
// Per-register pending-write counters; x0 is never tracked so it always reads zero.
module issue_scoreboard
  import decode_issue_controller_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc_en,
  input  logic [4:0]        inc_idx,
  input  logic              dec_en,
  input  logic [4:0]        dec_idx,
  input  logic [4:0]        rd1_idx,
  input  logic [4:0]        rd2_idx,
  input  logic [4:0]        sat_idx,
  output logic [PEND_W-1:0] rd1_cnt,
  output logic [PEND_W-1:0] rd2_cnt,
  output logic              sat
);

  localparam logic [PEND_W-1:0] SAT_VAL = '1;

  logic [PEND_W-1:0]    pend [REG_COUNT];
  logic [REG_COUNT-1:0] inc_vec;
  logic [REG_COUNT-1:0] dec_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en && inc_idx != 5'd0) inc_vec[inc_idx] = 1'b1;
    if (dec_en && dec_idx != 5'd0) dec_vec[dec_idx] = 1'b1;
  end

  // A register hit by both increment and decrement in one cycle nets to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int r = 0; r < REG_COUNT; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          assert (pend[r] != SAT_VAL);
          if (pend[r] != SAT_VAL) pend[r] <= pend[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          assert (pend[r] != '0);
          if (pend[r] != '0) pend[r] <= pend[r] - 1'b1;
        end
      end
    end
  end

  assign rd1_cnt = pend[rd1_idx];
  assign rd2_cnt = pend[rd2_idx];
  assign sat     = (pend[sat_idx] == SAT_VAL);

endmodule

// File: rtl/decode_issue_controller.sv
// Issue control: RAW/capacity/serialization hazards, in-flight tracking and flush.
module decode_issue_controller
  import decode_issue_controller_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int PEND_W       = PEND_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  decode_issue_controller_if.slave bus,
  input  logic                  flush,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  serial_busy
);

  IssueState             state;
  logic [PEND_W-1:0]     rd1_cnt;
  logic [PEND_W-1:0]     rd2_cnt;
  logic                  dst_sat;
  logic                  hazard;
  logic                  iss_valid;
  logic                  fire;
  logic [INFLIGHT_W-1:0] inflight_next;

  issue_scoreboard #(.PEND_W(PEND_W)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .inc_en  (fire && bus.dec_writes_dst),
    .inc_idx (bus.dec_dst),
    .dec_en  (bus.cmpl_valid && bus.cmpl_writes_dst),
    .dec_idx (bus.cmpl_dst),
    .rd1_idx (bus.dec_src1),
    .rd2_idx (bus.dec_src2),
    .sat_idx (bus.dec_dst),
    .rd1_cnt (rd1_cnt),
    .rd2_cnt (rd2_cnt),
    .sat     (dst_sat)
  );

  // Hazards look only at registered state; completions are not bypassed.
  always_comb begin
    hazard = (bus.dec_uses_src1 && rd1_cnt != '0)
          || (bus.dec_uses_src2 && rd2_cnt != '0)
          || (bus.dec_writes_dst && bus.dec_dst != 5'd0 && dst_sat)
          || (inflight == INFLIGHT_W'(MAX_INFLIGHT))
          || (state == SERIAL_BUSY)
          || (bus.dec_serial && inflight != '0);
    iss_valid = bus.dec_valid && !hazard && !flush && !rst;
    fire      = iss_valid && bus.iss_ready;
    case ({fire, bus.cmpl_valid})
      2'b10:   inflight_next = inflight + 1'b1;
      2'b01:   inflight_next = (inflight == '0) ? '0 : inflight - 1'b1;
      default: inflight_next = inflight;
    endcase
  end

  assign bus.iss_valid = iss_valid;
  assign bus.dec_stall = bus.dec_valid && !fire && !flush && !rst;
  assign serial_busy   = (state == SERIAL_BUSY) && !rst;

  // A serializing op parks the FSM until the pipeline fully drains behind it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= RUN;
      inflight <= '0;
    end else begin
      assert (!(bus.cmpl_valid && inflight == '0));
      inflight <= inflight_next;
      case (state)
        RUN:         if (fire && bus.dec_serial) state <= SERIAL_BUSY;
        SERIAL_BUSY: if (inflight_next == '0) state <= RUN;
        default:     state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Directed bench for decode_issue_controller: hazards, capacity, serialization, flush, reset.
module tb_decode_issue_controller;
  import decode_issue_controller_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [INFLIGHT_W-1:0] inflight;
  logic                  serial_busy;
  int                    errors = 0;
  int                    checks = 0;

  decode_issue_controller_if bus ();

  decode_issue_controller #(.MAX_INFLIGHT(4), .PEND_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .inflight    (inflight),
    .serial_busy (serial_busy)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                          input logic u2, input logic [4:0] d, input logic wd, input logic ser);
    bus.dec_valid = 1'b1;  bus.dec_src1 = s1; bus.dec_uses_src1 = u1;
    bus.dec_src2 = s2;     bus.dec_uses_src2 = u2;
    bus.dec_dst = d;       bus.dec_writes_dst = wd; bus.dec_serial = ser;
  endtask

  task automatic drive_idle();
    bus.dec_valid = 1'b0; bus.dec_uses_src1 = 1'b0; bus.dec_uses_src2 = 1'b0;
    bus.dec_writes_dst = 1'b0; bus.dec_serial = 1'b0;
  endtask

  task automatic drive_cmpl(input logic en, input logic wd, input logic [4:0] d);
    bus.cmpl_valid = en; bus.cmpl_writes_dst = wd; bus.cmpl_dst = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bus.iss_ready = 1'b1;
    drive_cmpl(1'b0, 1'b0, 5'd0);
    drive_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_iss_valid: got %0b want 0", bus.iss_valid); end
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_dec_stall: got %0b want 0", bus.dec_stall); end
    checks++; if (serial_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_serial_busy: got %0b want 0", serial_busy); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL reset_inflight: got %0d want 0", inflight); end
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_raw_stall();
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL raw_producer_issue: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); #1;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall: got %0b want 1", bus.dec_stall); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL raw_iss_valid_low: got %0b want 0", bus.iss_valid); end
    @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'd5); #1;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_no_bypass: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL raw_issue_after_cmpl: got %0b want 1", bus.iss_valid); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL raw_inflight_zero: got %0d want 0", inflight); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (inflight !== 4'd1) begin errors++; $display("[TB] FAIL raw_inflight_one: got %0d want 1", inflight); end
    @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'd6);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL raw_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_x0_and_same_cycle();
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL x0_writer_issue: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_op(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL x0_reader_no_stall: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_idle(); drive_cmpl(1'b1, 1'b1, 5'd0); #1;
    checks++; if (inflight !== 4'd2) begin errors++; $display("[TB] FAIL x0_inflight_two: got %0d want 2", inflight); end
    @(negedge clk);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0);
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'd7); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL x7_second_writer: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); drive_op(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    checks++; if (inflight !== 4'd1) begin errors++; $display("[TB] FAIL x7_inflight_net: got %0d want 1", inflight); end
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL x7_pend_kept: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'd7);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL x7_pend_drained: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_idle(); drive_cmpl(1'b1, 1'b0, 5'd0);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL x7_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_capacity();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + i), 1'b1, 1'b0); #1;
      checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap_issue_%0d: got %0b want 1", i, bus.iss_valid); end
    end
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0); drive_cmpl(1'b1, 1'b1, 5'd10); #1;
    checks++; if (inflight !== 4'd4) begin errors++; $display("[TB] FAIL cap_inflight_full: got %0d want 4", inflight); end
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL cap_fifth_stalled: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap_fifth_issue: got %0b want 1", bus.iss_valid); end
    checks++; if (inflight !== 4'd3) begin errors++; $display("[TB] FAIL cap_inflight_three: got %0d want 3", inflight); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (inflight !== 4'd4) begin errors++; $display("[TB] FAIL cap_inflight_back_to_four: got %0d want 4", inflight); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'(11 + i));
    end
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL cap_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_serialization();
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); #1;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL serial_wait_two: got %0b want 1", bus.dec_stall); end
    checks++; if (inflight !== 4'd2) begin errors++; $display("[TB] FAIL serial_inflight_two: got %0d want 2", inflight); end
    drive_cmpl(1'b1, 1'b1, 5'd1);
    @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'd2); #1;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL serial_wait_one: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL serial_issue: got %0b want 1", bus.iss_valid); end
    checks++; if (serial_busy !== 1'b0) begin errors++; $display("[TB] FAIL serial_busy_before: got %0b want 0", serial_busy); end
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); #1;
    checks++; if (serial_busy !== 1'b1) begin errors++; $display("[TB] FAIL serial_busy_set: got %0b want 1", serial_busy); end
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL serial_follower_stall: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_cmpl(1'b1, 1'b1, 5'd3); #1;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL serial_follower_still_stall: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (serial_busy !== 1'b0) begin errors++; $display("[TB] FAIL serial_release: got %0b want 0", serial_busy); end
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL serial_follower_issue: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_idle(); drive_cmpl(1'b1, 1'b1, 5'd4);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL serial_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    end
    @(negedge clk); #1;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_dst_saturated: got %0b want 1", bus.dec_stall); end
    checks++; if (inflight !== 4'd3) begin errors++; $display("[TB] FAIL flush_inflight_three: got %0d want 3", inflight); end
    @(negedge clk); flush = 1'b1; drive_cmpl(1'b1, 1'b1, 5'd3); #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_iss_valid: got %0b want 0", bus.iss_valid); end
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_dec_stall: got %0b want 0", bus.dec_stall); end
    @(negedge clk); flush = 1'b0; drive_cmpl(1'b0, 1'b0, 5'd0);
    drive_op(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL flush_inflight_cleared: got %0d want 0", inflight); end
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pend_cleared: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_idle(); drive_cmpl(1'b1, 1'b0, 5'd0);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); #1;
    checks++; if (serial_busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_serial_busy: got %0b want 1", serial_busy); end
    @(negedge clk); flush = 1'b1; drive_cmpl(1'b1, 1'b1, 5'd3); #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_serial_iss_valid: got %0b want 0", bus.iss_valid); end
    @(negedge clk); flush = 1'b0; drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (serial_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_state_run: got %0b want 0", serial_busy); end
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_follower_issue: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_idle(); drive_cmpl(1'b1, 1'b1, 5'd9);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL flush_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); bus.iss_ready = 1'b0; drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_iss_valid: got %0b want 1", bus.iss_valid); end
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("[TB] FAIL bp_dec_stall: got %0b want 1", bus.dec_stall); end
    @(negedge clk); drive_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_scoreboard_unchanged: got %0b want 1", bus.iss_valid); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL bp_inflight: got %0d want 0", inflight); end
    @(negedge clk); drive_idle(); bus.iss_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    @(negedge clk); rst = 1'b1; drive_op(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_iss_valid: got %0b want 0", bus.iss_valid); end
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_dec_stall: got %0b want 0", bus.dec_stall); end
    checks++; if (serial_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_serial_busy: got %0b want 0", serial_busy); end
    @(negedge clk); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_inflight: got %0d want 0", inflight); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pend_cleared: got %0b want 1", bus.iss_valid); end
    @(negedge clk); drive_idle(); drive_cmpl(1'b1, 1'b0, 5'd0);
    @(negedge clk); drive_cmpl(1'b0, 1'b0, 5'd0); #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_drained: got %0d want 0", inflight); end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_x0_and_same_cycle();
    test_capacity();
    test_serialization();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_issue_controller.md
Name: decode_issue_controller

Overview:
- Sequences ops from the decode stage into the register-read/execute pipeline.
- Holds a per-register scoreboard of pending writes and an in-flight op counter.
- Issues an op only when it has no RAW hazard, the scoreboard is not saturated and serialization rules allow. Otherwise it stalls decode.
- Serializes CSR and trap-carrying ops against the whole pipeline, and clears all tracking on pipeline flush.

Parameters:
- MAX_INFLIGHT, 4, max issued-but-not-completed ops; range 1..15.
- PEND_W, 2, width of each per-register pending-write counter; saturates at 2^PEND_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode stage holds a valid op
- dec_src1  in  5  source register 1 address
- dec_src2  in  5  source register 2 address
- dec_uses_src1  in  1  op reads src1
- dec_uses_src2  in  1  op reads src2
- dec_dst  in  5  destination register address
- dec_writes_dst  in  1  op writes dst
- dec_serial  in  1  op is a CSR access or carries a valid trap
- iss_ready  in  1  downstream accepts an op this cycle
- iss_valid  out  1  op offered downstream
- dec_stall  out  1  decode must hold its current op
- cmpl_valid  in  1  one previously issued op completes this cycle
- cmpl_writes_dst  in  1  the completing op wrote a register
- cmpl_dst  in  5  destination of the completing op
- flush  in  1  kill all in-flight and decode ops
- inflight  out  4  current in-flight count
- serial_busy  out  1  a serializing op is outstanding

Behaviour:
- Reset (rst=1 at posedge): all pending counters=0, inflight=0, state=RUN. Outputs while in reset: iss_valid=0, dec_stall=0, serial_busy=0.
- Register x0 is never tracked:
  - issuing or completing with dst=0 leaves its counter unchanged;
  - reads of x0 never hazard.
- Hazard (combinational, from registered state only; no same-cycle completion bypass). Any of the following is a hazard:
  - dec_uses_src1 and pend[src1]!=0;
  - dec_uses_src2 and pend[src2]!=0;
  - dec_writes_dst and dst!=0 and pend[dst] is saturated;
  - inflight==MAX_INFLIGHT;
  - state==SERIAL_BUSY;
  - dec_serial and inflight!=0.
- iss_valid = dec_valid & ~hazard & ~flush & ~rst.
- fire = iss_valid & iss_ready.
- dec_stall = dec_valid & ~fire & ~flush.
- Issue-to-downstream latency is 0 cycles (combinational offer). Scoreboard updates become visible the next cycle.
- inflight next = inflight + fire - cmpl_valid. Simultaneous fire and cmpl leaves it unchanged.
- pend[r] next = pend[r] + (fire & writes_dst & dst==r) - (cmpl_valid & cmpl_writes_dst & cmpl_dst==r). Same register on both sides in one cycle gives net 0.
- Error conditions:
  - cmpl_valid with inflight==0, or a decrement of pend==0: protocol error. Assertion fails; the counter holds at 0.
  - An increment past saturation is impossible by the hazard rule; an assertion covers it.
- State machine:
  - RUN -> SERIAL_BUSY on fire & dec_serial.
  - SERIAL_BUSY -> RUN when next inflight==0, i.e. the serial op completes.
  - Any state -> RUN on flush.
- serial_busy = (state==SERIAL_BUSY).
- Flush (highest priority after rst):
  - next cycle all pend=0, inflight=0, state=RUN;
  - same-cycle fire and cmpl are ignored;
  - iss_valid forced 0 that cycle.
- Downstream guarantees that killed ops never produce cmpl_valid after a flush.
- Back-pressure: with iss_valid=1 and iss_ready=0, dec_stall=1 and the scoreboard is unchanged. iss_valid may drop if decode inputs change; the controller does not latch the op.

Decomposition:
- Shared package additions:
  - IssueState enum (RUN, SERIAL_BUSY);
  - constants REG_COUNT=32 and INFLIGHT_W=4;
  - typedef pend_cnt_t logic[PEND_W-1:0].
- One natural sub-module: issue_scoreboard. It holds the 32 pending counters with increment, decrement and clear ports, and provides two read ports plus a saturation query for dst.
- The controller top holds the FSM, the inflight counter and the hazard/issue logic.

Test Plan:
- RAW stall:
  - stimulus: issue dst=x5; next cycle decode op with src1=x5, iss_ready=1.
  - required: dec_stall=1 until cmpl(x5); iss_valid=1 the cycle after cmpl.
- x0 and same-cycle update:
  - stimulus: issue dst=x0, then an op reading x0.
  - required: no stall, pend unchanged.
  - stimulus: fire with dst=x7 in the same cycle as cmpl dst=x7 while pend[x7]=1.
  - required: pend[x7] stays 1.
- Capacity:
  - stimulus: issue 4 independent ops with no completions.
  - required: inflight=4, 5th op stalled.
  - stimulus: one cmpl.
  - required: 5th op issues next cycle; inflight stays 4.
- Serialization:
  - stimulus: with inflight=2, decode a CSR op.
  - required: stalled until inflight=0, then issues; serial_busy=1; following op stalled until the CSR cmpl; serial_busy=0 and the follower issues the next cycle.
- Flush:
  - stimulus: in SERIAL_BUSY with pend[x3]=2 and inflight=3, assert flush together with cmpl.
  - required: next cycle inflight=0, all pend=0, state=RUN, iss_valid=0 during the flush cycle.
- Reset mid-operation:
  - stimulus: assert rst with nonzero state.
  - required: all counters 0 next cycle, iss_valid=0 and dec_stall=0 while rst=1.
